// File: rtl/regfile_pkg.sv
// Shared sizing and types for the general-purpose register file.
package regfile_pkg;

    localparam int unsigned REG_WIDTH  = 3;
    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned NUM_REGS   = 2 ** REG_WIDTH;
    localparam int unsigned ZERO_REG   = 0;

    typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/reg_file_rdport.sv
// Combinational read port: register select, r0 forced to zero, optional write-through.
// Forwarding is compiled in when REG_FILE_BYPASS_EN is defined.
module reg_file_rdport #(
    parameter int unsigned REG_WIDTH  = regfile_pkg::REG_WIDTH,
    parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH
) (
    input  logic [(2**REG_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
    input  logic [REG_WIDTH-1:0]                      rd_addr,
    input  logic [REG_WIDTH-1:0]                      wr_addr,
    input  logic [DATA_WIDTH-1:0]                     wr_data,
    input  logic                                      fwd_en,
    output logic [DATA_WIDTH-1:0]                     rd_data
);
    import regfile_pkg::*;

    logic is_zero;

    assign is_zero = (rd_addr == REG_WIDTH'(ZERO_REG));

`ifdef REG_FILE_BYPASS_EN
    logic hit;

    // fwd_en already excludes reset; the zero-register check keeps r0 reading 0
    assign hit = fwd_en && (wr_addr == rd_addr);

    always_comb begin
        rd_data = regs[rd_addr];
        if (hit) begin
            rd_data = wr_data;
        end
        if (is_zero) begin
            rd_data = '0;
        end
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{wr_addr, wr_data, fwd_en};

    always_comb begin
        rd_data = regs[rd_addr];
        if (is_zero) begin
            rd_data = '0;
        end
    end
`endif

endmodule

// File: rtl/reg_file.sv
// 2R/1W register file with hardwired-zero r0 and a written-since-reset bitmap.
// Optional same-cycle write-through forwarding via REG_FILE_BYPASS_EN.
module reg_file #(
    parameter int unsigned REG_WIDTH  = regfile_pkg::REG_WIDTH,
    parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_WIDTH-1:0]      rd_addr1,
    input  logic [REG_WIDTH-1:0]      rd_addr2,
    input  logic [REG_WIDTH-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      wr_en,
    output logic [DATA_WIDTH-1:0]     rd_data1,
    output logic [DATA_WIDTH-1:0]     rd_data2,
    output logic [(2**REG_WIDTH)-1:0] written
);
    import regfile_pkg::*;

    localparam int unsigned NREGS = 2 ** REG_WIDTH;

    logic [NREGS-1:0][DATA_WIDTH-1:0] regs_q;
    logic [NREGS-1:0]                 written_q;
    logic                             wr_fire;
    logic                             fwd_en;

    assign wr_fire = wr_en && (wr_addr != REG_WIDTH'(ZERO_REG));
    assign fwd_en  = wr_fire && rst_n;

    // Reset wins over a same-edge write; r0 is never stored to
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q    <= '0;
            written_q <= '0;
        end else if (wr_fire) begin
            regs_q[wr_addr]    <= wr_data;
            written_q[wr_addr] <= 1'b1;
        end
    end

    assign written = written_q;

    reg_file_rdport #(
        .REG_WIDTH  (REG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rdport1 (
        .regs    (regs_q),
        .rd_addr (rd_addr1),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .fwd_en  (fwd_en),
        .rd_data (rd_data1)
    );

    reg_file_rdport #(
        .REG_WIDTH  (REG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rdport2 (
        .regs    (regs_q),
        .rd_addr (rd_addr2),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .fwd_en  (fwd_en),
        .rd_data (rd_data2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (REG_WIDTH = 3, DATA_WIDTH = 16).
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic [2:0]  rd_addr1;
    logic [2:0]  rd_addr2;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_en;
    logic [15:0] rd_data1;
    logic [15:0] rd_data2;
    logic [7:0]  written;

    int tests_run;
    int tests_failed;

    reg_file #(
        .REG_WIDTH  (3),
        .DATA_WIDTH (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .written  (written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [2:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n    = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        tick();

        // Preload r1..r7 with all-ones
        for (int i = 1; i < 8; i++) begin
            write(3'(i), 16'hFFFF);
        end
        rd_addr1 = 3'd7;
        rd_addr2 = 3'd1;
        #1;
        check("preload_r7", {16'h0, rd_data1}, 32'hFFFF);
        check("preload_r1", {16'h0, rd_data2}, 32'hFFFF);
        check("preload_written", {24'h0, written}, 32'h00FE);

        // Reset clears everything
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addr1 = 3'(i);
            rd_addr2 = 3'(7 - i);
            #1;
            check($sformatf("reset_rd1_r%0d", i), {16'h0, rd_data1}, 32'h0);
            check($sformatf("reset_rd2_r%0d", 7 - i), {16'h0, rd_data2}, 32'h0);
        end
        check("reset_written", {24'h0, written}, 32'h0);

        // Write then read on both ports
        write(3'd5, 16'hA5A5);
        rd_addr1 = 3'd5;
        rd_addr2 = 3'd5;
        #1;
        check("wr5_rd1", {16'h0, rd_data1}, 32'hA5A5);
        check("wr5_rd2", {16'h0, rd_data2}, 32'hA5A5);
        check("wr5_written", {24'h0, written}, 32'h0020);

        // Zero register: also check before the edge (no forwarding to r0)
        wr_en    = 1'b1;
        wr_addr  = 3'd0;
        wr_data  = 16'h1234;
        rd_addr1 = 3'd0;
        #1;
        check("r0_pre_edge", {16'h0, rd_data1}, 32'h0);
        tick();
        wr_en = 1'b0;
        check("r0_post_edge", {16'h0, rd_data1}, 32'h0);
        check("r0_written_bit", {31'h0, written[0]}, 32'h0);
        check("r0_written", {24'h0, written}, 32'h0020);

        // Reset priority over a simultaneous write
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 3'd3;
        wr_data = 16'h00FF;
        tick();
        rst_n    = 1'b1;
        wr_en    = 1'b0;
        rd_addr1 = 3'd3;
        rd_addr2 = 3'd5;
        #1;
        check("rstprio_r3", {16'h0, rd_data1}, 32'h0);
        check("rstprio_r5", {16'h0, rd_data2}, 32'h0);
        check("rstprio_written", {24'h0, written}, 32'h0);

        // Same-cycle read of the write address
        write(3'd2, 16'h1111);
        wr_en    = 1'b1;
        wr_addr  = 3'd2;
        wr_data  = 16'h2222;
        rd_addr2 = 3'd2;
        rd_addr1 = 3'd5;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("same_cycle_rd2", {16'h0, rd_data2}, 32'h2222);
`else
        check("same_cycle_rd2", {16'h0, rd_data2}, 32'h1111);
`endif
        check("same_cycle_other", {16'h0, rd_data1}, 32'h0);
        tick();
        wr_en = 1'b0;
        check("after_edge_rd2", {16'h0, rd_data2}, 32'h2222);
        check("after_edge_written", {24'h0, written}, 32'h0004);

        // Disabled write, including X on addresses
        write(3'd7, 16'h7777);
        wr_en   = 1'b0;
        wr_addr = 3'd7;
        wr_data = 16'hBEEF;
        repeat (3) tick();
        wr_addr  = 'x;
        rd_addr1 = 'x;
        rd_addr2 = 'x;
        tick();
        rd_addr1 = 3'd7;
        rd_addr2 = 3'd2;
        #1;
        check("disabled_r7", {16'h0, rd_data1}, 32'h7777);
        check("disabled_r2", {16'h0, rd_data2}, 32'h2222);
        check("disabled_written", {24'h0, written}, 32'h0084);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
